// File: rtl/qlab5_sys_onchip_ram_dp.sv
// Dual-port on-chip RAM, single clock, byte enables, READ_LATENCY 1 or 2.
// Define ONCHIP_RAM_PARITY_EN for per-byte even parity with sticky error flags.
module qlab5_sys_onchip_ram_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 11,
    parameter int DEPTH        = 2048,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "onchip_memory2_0.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                waitrequest
`ifdef ONCHIP_RAM_PARITY_EN
   ,output logic                s1_parity_err,
    output logic                s2_parity_err
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST  = READ_LATENCY - 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Image is attached through the vendor RAM-init attribute.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem [DEPTH];

    logic              en;
    logic [ADDR_W-1:0] addr [2];
    logic [IDX_W-1:0]  idx  [2];
    logic [NB-1:0]     be   [2];
    logic [DATA_W-1:0] wd   [2];
    logic [DATA_W-1:0] rdat [2];
    logic [1:0]        cs, rd, wr;
    logic [1:0]        in_rng, acc_rd, acc_wr;

    logic [READ_LATENCY-1:0] vld [2];
    logic [DATA_W-1:0]       dat [2][READ_LATENCY];

    assign en          = clken & ~reset_req;
    assign waitrequest = ~en;

    assign addr[0] = s1_address;
    assign addr[1] = s2_address;
    assign be[0]   = s1_byteenable;
    assign be[1]   = s2_byteenable;
    assign wd[0]   = s1_writedata;
    assign wd[1]   = s2_writedata;
    assign cs      = {s2_chipselect, s1_chipselect};
    assign rd      = {s2_read, s1_read};
    assign wr      = {s2_write, s1_write};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx[p]    = addr[p][IDX_W-1:0];
            in_rng[p] = {1'b0, addr[p]} < DEPTH_C;
            acc_wr[p] = cs[p] & wr[p] & en & ~reset;
            acc_rd[p] = cs[p] & rd[p] & ~wr[p] & en;
            rdat[p]   = in_rng[p] ? mem[idx[p]] : '0;
        end
        // Port 1 owns a colliding write; port 2 is dropped whole.
        if (acc_wr[0] && addr[0] == addr[1])
            acc_wr[1] = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < NB; b++)
                if (acc_wr[p] && in_rng[p] && be[p][b])
                    mem[idx[p]][8*b +: 8] <= wd[p][8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                vld[p] <= '0;
                for (int i = 0; i < READ_LATENCY; i++)
                    dat[p][i] <= '0;
            end
        end else if (en) begin
            for (int p = 0; p < 2; p++) begin
                vld[p][0] <= acc_rd[p];
                if (acc_rd[p])
                    dat[p][0] <= rdat[p];
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vld[p][i] <= vld[p][i-1];
                    if (vld[p][i-1])
                        dat[p][i] <= dat[p][i-1];
                end
            end
        end
    end

    assign s1_readdata      = dat[0][LAST];
    assign s1_readdatavalid = vld[0][LAST];
    assign s2_readdata      = dat[1][LAST];
    assign s2_readdatavalid = vld[1][LAST];

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0]           pmem  [DEPTH];
    logic [1:0]              perr;
    logic [READ_LATENCY-1:0] epipe [2];
    logic [1:0]              sticky;

    function automatic logic [NB-1:0] bpar(input logic [DATA_W-1:0] d);
        bpar = '0;
        for (int b = 0; b < NB; b++)
            bpar[b] = ^d[8*b +: 8];
    endfunction

    always_comb begin
        for (int p = 0; p < 2; p++)
            perr[p] = in_rng[p] & (|(pmem[idx[p]] ^ bpar(rdat[p])));
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < NB; b++)
                if (acc_wr[p] && in_rng[p] && be[p][b])
                    pmem[idx[p]][b] <= ^wd[p][8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= '0;
            for (int p = 0; p < 2; p++)
                epipe[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (en) begin
                    epipe[p][0] <= perr[p] & acc_rd[p];
                    for (int i = 1; i < READ_LATENCY; i++)
                        epipe[p][i] <= epipe[p][i-1];
                end
                sticky[p] <= sticky[p] | (vld[p][LAST] & epipe[p][LAST]);
            end
        end
    end

    assign s1_parity_err = sticky[0];
    assign s2_parity_err = sticky[1];
`endif

endmodule
